// File: rtl/spi_slave_sync.sv
// SPI slave (LSB first, sample on sclk fall, launch on sclk rise) fully synchronised to i_clk.
// Define SPI_SLV_ECHO_EN to send the last received byte when no tx byte is held.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_cs,
    input  logic       i_sdi,
    output logic       o_sdo,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    typedef enum logic {StIdle = 1'b0, StShift = 1'b1} state_e;

    state_e                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sdi_sync, r_fill;
    logic                   r_sclk_prev, r_cs_prev, r_cs_armed;
    logic [2:0]             r_cnt;
    logic [7:0]             r_tx_shift, r_hold, r_rx_data;
    logic [6:0]             r_rx_shift;
    logic                   r_hold_full, r_sdo, r_rx_valid, r_frame_err;

    logic       w_sclk_s, w_cs_s, w_sdi_s;
    logic       w_sclk_fall, w_sclk_rise, w_cs_fall, w_cs_rise;
    logic       w_start, w_stop, w_fall_ev, w_rise_ev, w_byte_done, w_load;
    logic       w_accept;
    logic [7:0] w_rx_byte, w_fallback, w_load_byte;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi_s  = r_sdi_sync[SYNC_STAGES-1];

    // r_fill marks when the chain holds real pin samples; cs must be seen high after
    // that before a falling edge may open a frame (cs held low through reset is ignored).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_sdi_sync  <= '0;
            r_fill      <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_cs_armed  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            if (r_fill[SYNC_STAGES-1] && w_cs_s) begin
                r_cs_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;
    assign w_sclk_rise = ~r_sclk_prev & w_sclk_s;
    assign w_cs_fall   = r_cs_prev & ~w_cs_s & r_cs_armed;
    assign w_cs_rise   = ~r_cs_prev & w_cs_s;

    assign w_start     = (r_state == StIdle) && w_cs_fall;
    assign w_stop      = (r_state == StShift) && w_cs_rise;
    assign w_fall_ev   = (r_state == StShift) && !w_cs_rise && w_sclk_fall;
    assign w_rise_ev   = (r_state == StShift) && !w_cs_rise && w_sclk_rise;
    assign w_byte_done = w_fall_ev && (r_cnt == 3'd7);
    assign w_load      = w_start || w_byte_done;
    assign w_rx_byte   = {w_sdi_s, r_rx_shift};

`ifdef SPI_SLV_ECHO_EN
    assign w_fallback = w_byte_done ? w_rx_byte : r_rx_data;
`else
    assign w_fallback = 8'h00;
`endif

    assign w_load_byte = r_hold_full ? r_hold : w_fallback;
    assign w_accept    = i_tx_valid && !r_hold_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_cs_fall) w_state_nxt = StShift;
            StShift: if (w_cs_rise) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        o_busy      = (r_state == StShift);
        o_sdo       = r_sdo;
        o_tx_ready  = ~r_hold_full;
        o_rx_data   = r_rx_data;
        o_rx_valid  = r_rx_valid;
        o_frame_err = r_frame_err;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= 3'd0;
            r_tx_shift  <= 8'h00;
            r_rx_shift  <= 7'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_sdo       <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_start) begin
                r_cnt      <= 3'd0;
                r_tx_shift <= w_load_byte;
                r_sdo      <= w_load_byte[0];
            end
            if (w_stop) begin
                r_cnt       <= 3'd0;
                r_sdo       <= 1'b0;
                r_frame_err <= (r_cnt != 3'd0);
            end
            if (w_fall_ev) begin
                r_rx_shift <= w_rx_byte[7:1];
                r_cnt      <= r_cnt + 3'd1;
                if (w_byte_done) begin
                    r_rx_data  <= w_rx_byte;
                    r_rx_valid <= 1'b1;
                    r_tx_shift <= w_load_byte;
                    r_sdo      <= w_load_byte[0];
                end
            end
            // counter 0 means bit 0 was already driven at load time
            if (w_rise_ev && (r_cnt != 3'd0)) begin
                r_sdo <= r_tx_shift[r_cnt];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_full <= 1'b0;
            r_hold      <= 8'h00;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold      <= i_tx_data;
        end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Randomised bench for spi_slave_sync: bit-banged SPI master plus a byte-slot reference model.
module tb_spi_slave_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: one held tx byte and the last complete rx byte
    logic       m_hold_full = 1'b0;
    logic [7:0] m_hold      = 8'h00;
    logic [7:0] m_last_rx   = 8'h00;

    logic [7:0] rxq[$];
    int         err_cnt = 0;
    logic [7:0] frame_tx[4];

    spi_slave_sync #(.SYNC_STAGES(2)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sclk     (sclk),
        .i_cs       (cs),
        .i_sdi      (sdi),
        .o_sdo      (sdo),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_frame_err(frame_err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (frame_err) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // byte sent to the master in the next slot
    task automatic model_slot(output logic [7:0] b);
        if (m_hold_full) begin
            b = m_hold;
            m_hold_full = 1'b0;
        end else begin
`ifdef SPI_SLV_ECHO_EN
            b = m_last_rx;
`else
            b = 8'h00;
`endif
        end
    endtask

    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sdi = mosi[i];
            wait_clk(2);
            sclk = 1'b1;
            wait_clk(4);
            miso[i] = sdo;
            sclk = 1'b0;
            wait_clk(4);
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_ready && t < 50) begin
            wait_clk(1);
            t++;
        end
        if (!tx_ready) begin
            check_eq("tx_ready_timeout", 32'(tx_ready), 32'd1);
        end else begin
            tx_valid = 1'b1;
            tx_data  = d;
            wait_clk(1);
            tx_valid = 1'b0;
            check_eq("tx_ready_drop", 32'(tx_ready), 32'd0);
            m_hold_full = 1'b1;
            m_hold      = d;
        end
    endtask

    task automatic check_rx(input int base, input int n);
        check_eq("rx_count", 32'(rxq.size()), 32'(base + n));
        for (int b = 0; b < n; b++) begin
            if (rxq.size() > base + b) check_eq("rx_byte", 32'(rxq[base+b]), 32'(frame_tx[b]));
        end
    endtask

    task automatic run_frame(input int n);
        int         base;
        logic [7:0] got, exp;
        base = rxq.size();
        cs = 1'b0;
        wait_clk(4);
        check_eq("busy_in_frame", 32'(busy), 32'd1);
        for (int b = 0; b < n; b++) begin
            model_slot(exp);
            spi_bits(frame_tx[b], 8, got);
            check_eq("miso", 32'(got), 32'(exp));
            m_last_rx = frame_tx[b];
        end
        cs = 1'b1;
        wait_clk(6);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("sdo_idle", 32'(sdo), 32'd0);
        check_eq("tx_ready_after", 32'(tx_ready), 32'(!m_hold_full));
        check_rx(base, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sdo"}, 32'(sdo), 32'd0);
        check_eq({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check_eq({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        int         base, errs;
        logic [7:0] got, exp0, exp1, rx_before;

        wait_clk(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(5);

        // single byte with a loaded tx byte
        load_tx(8'hA5);
        frame_tx[0] = 8'h3C;
        run_frame(1);
        check_eq("rx_data_3c", 32'(rx_data), 32'h3C);

        // two-byte frame, nothing loaded
        frame_tx[0] = 8'h11;
        frame_tx[1] = 8'h22;
        run_frame(2);

        // cs rises after 5 bits
        base = rxq.size();
        errs = err_cnt;
        rx_before = rx_data;
        cs = 1'b0;
        wait_clk(4);
        model_slot(exp0);
        spi_bits(8'hFF, 5, got);
        cs = 1'b1;
        wait_clk(6);
        check_eq("frame_err_pulses", 32'(err_cnt - errs), 32'd1);
        check_eq("abort_no_rx", 32'(rxq.size()), 32'(base));
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rx_data", 32'(rx_data), 32'(rx_before));

        for (int it = 0; it < 20; it++) begin
            int n;
            if (!m_hold_full && $urandom_range(1, 0) == 1) load_tx(8'($urandom));
            n = $urandom_range(3, 1);
            for (int b = 0; b < n; b++) frame_tx[b] = 8'($urandom);
            run_frame(n);
        end

        // reset mid-frame with cs held low
        base = rxq.size();
        errs = err_cnt;
        cs = 1'b0;
        wait_clk(4);
        spi_bits(8'h07, 3, got);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        wait_clk(3);
        rst = 1'b0;
        m_hold_full = 1'b0;
        m_last_rx   = 8'h00;
        wait_clk(4);
        spi_bits(8'hFF, 8, got);
        check_eq("no_frame_busy", 32'(busy), 32'd0);
        check_eq("no_frame_rx", 32'(rxq.size()), 32'(base));
        check_eq("no_frame_err", 32'(err_cnt - errs), 32'd0);
        cs = 1'b1;
        wait_clk(6);
        frame_tx[0] = 8'h5A;
        run_frame(1);

        // tx accepted in the same clk the frame loads its first byte
        base = rxq.size();
        cs = 1'b0;
        wait_clk(2);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        wait_clk(1);
        tx_valid = 1'b0;
        check_eq("same_clk_busy", 32'(busy), 32'd1);
        check_eq("same_clk_tx_ready", 32'(tx_ready), 32'd0);
        model_slot(exp0);
        m_hold_full = 1'b1;
        m_hold      = 8'hC3;
        wait_clk(2);
        frame_tx[0] = 8'h96;
        frame_tx[1] = 8'h4B;
        spi_bits(frame_tx[0], 8, got);
        check_eq("same_clk_miso0", 32'(got), 32'(exp0));
        m_last_rx = frame_tx[0];
        model_slot(exp1);
        spi_bits(frame_tx[1], 8, got);
        check_eq("same_clk_miso1", 32'(got), 32'(exp1));
        check_eq("same_clk_miso1_c3", 32'(got), 32'hC3);
        m_last_rx = frame_tx[1];
        cs = 1'b1;
        wait_clk(6);
        check_eq("same_clk_tx_ready_after", 32'(tx_ready), 32'd1);
        check_rx(base, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the synchronizer depth for sclk, cs and sdi; legal range 2..3.
REQ-002 clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-005 cs  input  1  chip select from master, active-low.
REQ-006 sdi  input  1  serial data from master (MOSI).
REQ-007 sdo  output  1  serial data to master (MISO).
REQ-008 tx_data  input  8  byte to transmit in a later SPI byte slot.
REQ-009 tx_valid  input  1  tx_data valid.
REQ-010 tx_ready  output  1  holding register empty; a byte is accepted when tx_valid and tx_ready are both high.
REQ-011 rx_data  output  8  last fully received byte.
REQ-012 rx_valid  output  1  one-clk pulse; rx_data updated in the same cycle.
REQ-013 frame_err  output  1  one-clk pulse; cs rose mid-byte.
REQ-014 busy  output  1  high while in SHIFT.

Function
REQ-015 sclk, cs and sdi shall each pass through a SYNC_STAGES-flop synchronizer; edges are detected on the synchronized signals.
REQ-016 Mode shall be LSB first: sdi sampled on the sclk falling edge, next sdo bit launched on the sclk rising edge, 8 bits per byte.
REQ-017 Legal input timing: sclk high and low phases each >= SYNC_STAGES+2 clk cycles, e.g. sclk = clk/8.
REQ-018 FSM states: IDLE and SHIFT.
REQ-019 IDLE -> SHIFT on a synchronized cs falling edge: load the byte, drive its bit 0 on sdo, and clear the 3-bit bit counter.
REQ-020 Load source: the holding register if full, which then empties; otherwise the fallback byte per REQ-033/034.
REQ-021 In SHIFT, each detected sclk falling edge shifts sdi into the receive register and increments the counter.
REQ-022 On the 8th falling edge of a byte, rx_data and rx_valid shall assert one clk after detection, i.e. SYNC_STAGES+1 clk after the pin edge.
REQ-023 After the 8th falling edge the counter wraps to 0 and the next byte is loaded; multi-byte frames are continuous with no gap.
REQ-024 On a sclk rising edge in SHIFT, sdo shall present the next bit of the current byte; with counter 0 the loaded bit 0 is held.
REQ-025 A cs rising edge in SHIFT with counter 0 returns to IDLE silently.
REQ-026 A cs rising edge in SHIFT with counter != 0 shall pulse frame_err, discard the partial byte with no rx_valid, and return to IDLE.
REQ-027 A cs falling edge and an sclk edge detected in the same clk: the cs edge is processed and the sclk edge is ignored.
REQ-028 tx_ready shall deassert the cycle after acceptance and reassert the cycle after the holding register is consumed.
REQ-029 Acceptance and consumption in the same cycle: the fallback byte is sent and the new byte fills the holding register.
REQ-030 While in IDLE, sdo shall be 0.

Reset
REQ-031 rst shall force: sdo=0, rx_data=0x00, rx_valid=0, frame_err=0, busy=0, tx_ready=1, holding register empty, state IDLE, counter 0, synchronizers at cs=1, sclk=0, sdi=0.
REQ-032 Reset mid-frame aborts with no rx_valid or frame_err. If cs is held low through reset, no frame starts until cs goes high and falls again.

Configuration
REQ-033 With SPI_SLV_ECHO_EN defined, the fallback byte shall be the last received rx_data (daisy-chain echo).
REQ-034 Without SPI_SLV_ECHO_EN, the fallback byte shall be 0x00.

Verification
REQ-035 Load tx 0xA5, then master sends 0x3C with sclk=clk/8 -> rx_valid once, rx_data=0x3C, master captures 0xA5 LSB first, tx_ready back to 1.
REQ-036 Two-byte frame 0x11 then 0x22 with no tx loaded -> two rx_valid pulses (0x11, 0x22); MISO returns 0x00, 0x00 without the macro, or prior rx then 0x11 with SPI_SLV_ECHO_EN.
REQ-037 cs rises after 5 bits of 0xFF -> frame_err one pulse, no rx_valid, busy=0, rx_data unchanged.
REQ-038 rst asserted after 3 bits, cs held low -> all outputs at reset values; no frame until cs toggles high then low; next 0x5A received correctly.
REQ-039 tx_valid raised in the same clk as the cs falling edge with holding empty -> first byte is fallback, second byte is the new tx_data.
